// File: rtl/data_mem_arbiter.sv
// Two-port (CPU / debug-loader) arbiter in front of a single-port synchronous data memory.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
   parameter int ABITS = 32,
   parameter int DBITS = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             we0,
   input  logic [ABITS-1:0] addr0,
   input  logic [DBITS-1:0] wdata0,
   input  logic             req1,
   input  logic             we1,
   input  logic [ABITS-1:0] addr1,
   input  logic [DBITS-1:0] wdata1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [DBITS-1:0] rdata0,
   output logic [DBITS-1:0] rdata1,
   output logic             mem_en,
   output logic             mem_we,
   output logic [ABITS-1:0] mem_addr,
   output logic [DBITS-1:0] mem_din,
   input  logic [DBITS-1:0] mem_dout,
   output logic [1:0]       fsm_state
);

   // Handshake: a requester holds reqN/weN/addrN/wdataN until it sees gntN (ISSUE cycle);
   // doneN follows one cycle later (RESP), with rdataN valid in that cycle on a read.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t           state;
   logic             cmd_we;
   logic             cmd_port;
   logic             pick1;
   logic             sel_we;
   logic [ABITS-1:0] sel_addr;
   logic [DBITS-1:0] sel_din;

`ifdef ARB_ROUND_ROBIN_EN
   logic             last_gnt;

   // On contention, port 1 wins only if port 0 was granted last.
   always_comb pick1 = req1 & (~req0 | ~last_gnt);
`else
   always_comb pick1 = req1 & ~req0;
`endif

   always_comb begin
      sel_we   = pick1 ? we1    : we0;
      sel_addr = pick1 ? addr1  : addr0;
      sel_din  = pick1 ? wdata1 : wdata0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cmd_we   <= 1'b0;
         cmd_port <= 1'b0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_gnt <= 1'b1;
`endif
      end else begin
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         done0  <= 1'b0;
         done1  <= 1'b0;
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (req0 | req1) begin
                  state    <= ISSUE;
                  cmd_port <= pick1;
                  cmd_we   <= sel_we;
                  mem_addr <= sel_addr;
                  mem_din  <= sel_din;
                  gnt0     <= ~pick1;
                  gnt1     <= pick1;
                  mem_en   <= ~sel_we;
                  mem_we   <= sel_we;
`ifdef ARB_ROUND_ROBIN_EN
                  last_gnt <= pick1;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE: begin
               // Requests are not sampled here; the granted port is still holding its old one.
               state <= RESP;
               done0 <= ~cmd_port;
               done1 <= cmd_port;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read data is passed straight through from the memory in the RESP cycle.
   assign rdata0    = (done0 & ~cmd_we) ? mem_dout : '0;
   assign rdata1    = (done1 & ~cmd_we) ? mem_dout : '0;
   assign fsm_state = state;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small synchronous memory model on the memory port.
// Expected grant order under contention depends on ARB_ROUND_ROBIN_EN.
module tb_data_mem_arbiter;

   localparam int ABITS = 32;
   localparam int DBITS = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req0, we0, req1, we1;
   logic [ABITS-1:0] addr0, addr1;
   logic [DBITS-1:0] wdata0, wdata1;
   logic             gnt0, gnt1, done0, done1;
   logic [DBITS-1:0] rdata0, rdata1;
   logic             mem_en, mem_we;
   logic [ABITS-1:0] mem_addr;
   logic [DBITS-1:0] mem_din;
   logic [DBITS-1:0] mem_dout;
   logic [1:0]       fsm_state;

   logic [DBITS-1:0] mem [0:15];
   int               checks = 0;
   int               failures = 0;

   data_mem_arbiter #(.ABITS(ABITS), .DBITS(DBITS)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   // Synchronous memory: write on mem_we, read data valid the cycle after mem_en.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[3:0]] = mem_din;
      if (mem_en) mem_dout = mem[mem_addr[3:0]];
   end

   // Exclusivity of strobes, grants and completions in every cycle.
   always @(negedge clk) begin
      checks++;
      if ({mem_en & mem_we, gnt0 & gnt1, done0 & done1} !== 3'b000) begin
         failures++;
         $display("FAIL exclusive t=%0t got en&we=%b gnt0&gnt1=%b done0&done1=%b required all 0",
                  $time, mem_en & mem_we, gnt0 & gnt1, done0 & done1);
      end
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog got timeout required finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   task automatic set_req(input int port, input logic we, input logic [ABITS-1:0] addr,
                          input logic [DBITS-1:0] wdata);
      if (port == 0) begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      end
   endtask

   task automatic idle_inputs();
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
   endtask

   task automatic test_reset();
      logic [5:0] ctrl;
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b0) begin
         failures++; $display("FAIL reset_ctrl got %b required 000000", ctrl);
      end
      checks++;
      if ({mem_addr, mem_din} !== '0) begin
         failures++; $display("FAIL reset_mem_bus got addr=%0h din=%0h required 0", mem_addr, mem_din);
      end
      checks++;
      if ({rdata0, rdata1} !== '0) begin
         failures++; $display("FAIL reset_rdata got %0h/%0h required 0", rdata0, rdata1);
      end
      checks++;
      if (fsm_state !== 2'd0) begin
         failures++; $display("FAIL reset_state got %0d required 0", fsm_state);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Port 0 writes f123 to addr 0, then reads it back with the read issued from RESP.
   task automatic test_write_read();
      logic [5:0] ctrl;
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'd0, 32'h0000f123);
      @(posedge clk);
      @(negedge clk);
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b100001 || mem_addr !== 32'd0 || mem_din !== 32'h0000f123) begin
         failures++;
         $display("FAIL wr_issue got ctrl=%b addr=%0h din=%0h required 100001 0 f123", ctrl, mem_addr, mem_din);
      end
      req0 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b001000) begin
         failures++; $display("FAIL wr_resp got ctrl=%b required 001000", ctrl);
      end
      set_req(0, 1'b0, 32'd0, 32'd0);
      @(posedge clk);
      @(negedge clk);
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b100010 || mem_addr !== 32'd0) begin
         failures++; $display("FAIL rd_issue got ctrl=%b addr=%0h required 100010 0", ctrl, mem_addr);
      end
      req0 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b001000 || rdata0 !== 32'h0000f123) begin
         failures++; $display("FAIL rd_resp got ctrl=%b rdata0=%0h required 001000 f123", ctrl, rdata0);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (fsm_state !== 2'd0 || {gnt0, gnt1, done0, done1, mem_en, mem_we} !== 6'b0) begin
         failures++; $display("FAIL wr_rd_idle got state=%0d required 0 with no strobes", fsm_state);
      end
   endtask

   // Port 1 writes addr 7, port 0 reads addr 7 requested during port 1's RESP.
   task automatic test_cross_port();
      logic [5:0] ctrl;
      @(posedge clk); #1;
      set_req(1, 1'b1, 32'd7, 32'h12345678);
      @(posedge clk);
      @(negedge clk);
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b010001 || mem_addr !== 32'd7) begin
         failures++; $display("FAIL xp_wr_issue got ctrl=%b addr=%0h required 010001 7", ctrl, mem_addr);
      end
      req1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b000100) begin
         failures++; $display("FAIL xp_wr_resp got ctrl=%b required 000100", ctrl);
      end
      set_req(0, 1'b0, 32'd7, 32'd0);
      @(posedge clk);
      @(negedge clk);
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b100010 || mem_addr !== 32'd7) begin
         failures++; $display("FAIL xp_rd_issue got ctrl=%b addr=%0h required 100010 7", ctrl, mem_addr);
      end
      req0 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b001000 || rdata0 !== 32'h12345678 || rdata1 !== 32'd0) begin
         failures++;
         $display("FAIL xp_rd_resp got ctrl=%b rdata0=%0h rdata1=%0h required 001000 12345678 0", ctrl, rdata0, rdata1);
      end
      @(posedge clk);
   endtask

   // Port 1 holds req across four reads of addr 0..3; one access every two cycles.
   task automatic test_back_to_back();
      logic [DBITS-1:0] pre [4];
      logic [5:0]       ctrl;
      pre[0] = 32'h00001000; pre[1] = 32'h00002001; pre[2] = 32'h00003002; pre[3] = 32'h00004003;
      for (int k = 0; k < 4; k++) mem[k] = pre[k];
      @(posedge clk); #1;
      set_req(1, 1'b0, 32'd0, 32'd0);
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
         checks++;
         if (i % 2 == 0) begin
            if (ctrl !== 6'b010010 || mem_addr !== 32'(i / 2)) begin
               failures++;
               $display("FAIL b2b_issue%0d got ctrl=%b addr=%0h required 010010 %0h", i / 2, ctrl, mem_addr, i / 2);
            end
            if (i / 2 < 3) addr1 = 32'(i / 2 + 1);
            else req1 = 1'b0;
         end else begin
            if (ctrl !== 6'b000100 || rdata1 !== pre[i / 2] || mem_addr !== 32'(i / 2)) begin
               failures++;
               $display("FAIL b2b_resp%0d got ctrl=%b rdata1=%0h addr=%0h required 000100 %0h %0h",
                        i / 2, ctrl, rdata1, mem_addr, pre[i / 2], i / 2);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (fsm_state !== 2'd0 || {gnt0, gnt1, done0, done1, mem_en, mem_we} !== 6'b0) begin
         failures++; $display("FAIL b2b_idle got state=%0d required 0 with no strobes", fsm_state);
      end
   endtask

   // Both ports request together: each writes its own address, then reads it back.
   task automatic test_contention();
      int               g_ord[$];
      int               d_ord[$];
      int               exp_ord [4];
      int               idx0, idx1;
      logic             last_we0, last_we1;
      logic [DBITS-1:0] v0, v1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 0; exp_ord[3] = 1;
`else
      exp_ord[0] = 0; exp_ord[1] = 0; exp_ord[2] = 1; exp_ord[3] = 1;
`endif
      v0 = 32'ha0a0a0a0; v1 = 32'hb1b1b1b1;
      idx0 = 0; idx1 = 0; last_we0 = 1'b1; last_we1 = 1'b1;
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'd8, v0);
      set_req(1, 1'b1, 32'd9, v1);
      for (int cyc = 0; cyc < 24 && d_ord.size() < 4; cyc++) begin
         @(negedge clk);
         if (done0) begin
            d_ord.push_back(0);
            if (!last_we0) begin
               checks++;
               if (rdata0 !== v0) begin
                  failures++; $display("FAIL cont_rdata0 got %0h required %0h", rdata0, v0);
               end
            end
         end
         if (done1) begin
            d_ord.push_back(1);
            if (!last_we1) begin
               checks++;
               if (rdata1 !== v1) begin
                  failures++; $display("FAIL cont_rdata1 got %0h required %0h", rdata1, v1);
               end
            end
         end
         if (gnt0) begin
            g_ord.push_back(0);
            last_we0 = we0;
            idx0++;
            if (idx0 < 2) set_req(0, 1'b0, 32'd8, 32'd0);
            else req0 = 1'b0;
         end
         if (gnt1) begin
            g_ord.push_back(1);
            last_we1 = we1;
            idx1++;
            if (idx1 < 2) set_req(1, 1'b0, 32'd9, 32'd0);
            else req1 = 1'b0;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      checks++;
      if (g_ord.size() != 4 || d_ord.size() != 4) begin
         failures++;
         $display("FAIL cont_count got grants=%0d dones=%0d required 4 4", g_ord.size(), d_ord.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= g_ord.size() || g_ord[i] != exp_ord[i]) begin
            failures++;
            $display("FAIL cont_grant%0d got %0d required %0d", i, (i < g_ord.size()) ? g_ord[i] : -1, exp_ord[i]);
         end
         checks++;
         if (i >= d_ord.size() || d_ord[i] != exp_ord[i]) begin
            failures++;
            $display("FAIL cont_done%0d got %0d required %0d", i, (i < d_ord.size()) ? d_ord[i] : -1, exp_ord[i]);
         end
      end
      repeat (3) @(posedge clk);
   endtask

   // Reset pulsed during the ISSUE cycle of a write to addr 5 must abort it cleanly.
   task automatic test_reset_mid();
      logic [5:0] ctrl;
      mem[5] = 32'h00000055;
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'd5, 32'hdeadbeef);
      @(posedge clk);
      @(negedge clk);
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b100001 || mem_addr !== 32'd5) begin
         failures++; $display("FAIL rst_issue got ctrl=%b addr=%0h required 100001 5", ctrl, mem_addr);
      end
      #1 rst_n = 1'b0;
      #1;
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b0 || fsm_state !== 2'd0) begin
         failures++; $display("FAIL rst_immediate got ctrl=%b state=%0d required 000000 0", ctrl, fsm_state);
      end
      req0 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b0 || mem[5] !== 32'h00000055) begin
         failures++; $display("FAIL rst_no_done got ctrl=%b mem5=%0h required 000000 55", ctrl, mem[5]);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_req(0, 1'b0, 32'd5, 32'd0);
      @(posedge clk);
      @(negedge clk);
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b100010 || mem_addr !== 32'd5) begin
         failures++; $display("FAIL rst_first_edge got ctrl=%b addr=%0h required 100010 5", ctrl, mem_addr);
      end
      req0 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      ctrl = {gnt0, gnt1, done0, done1, mem_en, mem_we};
      checks++;
      if (ctrl !== 6'b001000 || rdata0 !== 32'h00000055) begin
         failures++; $display("FAIL rst_readback got ctrl=%b rdata0=%0h required 001000 55", ctrl, rdata0);
      end
      @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      mem_dout = '0;
      idle_inputs();
      test_reset();
      test_write_read();
      test_cross_port();
      test_back_to_back();
      test_contention();
      test_reset_mid();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ABITS, default 32, address width.
REQ-002 The block SHALL have parameter DBITS, default 32, data width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports reqN  input  1  access request, N = 0, 1; port 0 is the CPU and port 1 is the debug/loader.
REQ-006 The block SHALL have ports weN  input  1  1 = write, 0 = read.
REQ-007 The block SHALL have ports addrN  input  ABITS  word address.
REQ-008 The block SHALL have ports wdataN  input  DBITS  write data.
REQ-009 The block SHALL have ports gntN  output  1  one-cycle grant pulse.
REQ-010 The block SHALL have ports doneN  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have ports rdataN  output  DBITS  read data, valid only with doneN on a read.
REQ-012 The block SHALL have port mem_en  output  1  memory read strobe.
REQ-013 The block SHALL have port mem_we  output  1  memory write strobe.
REQ-014 The block SHALL have port mem_addr  output  ABITS  memory address.
REQ-015 The block SHALL have port mem_din  output  DBITS  memory write data.
REQ-016 The block SHALL have port mem_dout  input  DBITS  memory read data, synchronous, valid the cycle after mem_en.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-018 In IDLE or RESP, on an edge with any reqN high, the block SHALL pick a winner, latch weN/addrN/wdataN into a command register and go to ISSUE; with no request it SHALL go to (or stay in) IDLE.
REQ-019 In ISSUE (1 cycle), gnt of the winner SHALL be 1; a read SHALL drive mem_en=1, mem_we=0; a write SHALL drive mem_en=0, mem_we=1; mem_addr/mem_din SHALL come from the command register; next state SHALL be RESP.
REQ-020 In RESP (1 cycle), done of the winner SHALL be 1; on a read, rdataN SHALL equal mem_dout combinationally.
REQ-021 Latency SHALL be: req sampled at edge N, gnt in cycle N+1, done in cycle N+2; sustained throughput SHALL be one access per 2 cycles (RESP->ISSUE).
REQ-022 mem_en and mem_we SHALL be 0 outside ISSUE and SHALL never both be 1.
REQ-023 mem_addr and mem_din SHALL hold their last value outside ISSUE.
REQ-024 A requester SHALL hold reqN, weN, addrN and wdataN stable until gntN; reqN high after gntN is a new request.
REQ-025 reqN SHALL be ignored during ISSUE and sampled in RESP alongside the other port.
REQ-026 gnt0/gnt1 SHALL be one-hot or zero, and likewise done0/done1.
REQ-027 A read after a write to the same address SHALL return the written data.

Reset
REQ-028 While rst_n=0, the block SHALL set state=IDLE; gntN, doneN, mem_en, mem_we=0; mem_addr, mem_din, rdataN=0; last-grant register=1.
REQ-029 Reset asserted mid-access SHALL deassert the strobes immediately and drop the access with no doneN.
REQ-030 The first edge after rst_n rises SHALL sample requests normally.

Configuration
REQ-031 With macro ARB_ROUND_ROBIN_EN defined, on contention the port not granted last SHALL win; the last-grant register SHALL update on every grant.
REQ-032 With ARB_ROUND_ROBIN_EN undefined, port 0 SHALL always win on contention, and the last-grant register SHALL be absent or unused.

Verification
REQ-033 The bench SHALL cover a port-0 write of 32'h0000f123 to addr 0 followed by a read of addr 0 -> gnt0 at N+1, done0 at N+2, rdata0=32'h0000f123.
REQ-034 The bench SHALL cover req0 and req1 held together, with both writes and then both reads -> RR: grants 0,1,0,1 with done order matching; no macro: port 0 is served every time port 0 requests.
REQ-035 The bench SHALL cover req1 held high across 4 reads of addr 0..3 -> gnt1 every 2 cycles, mem_en pulses alternate with done1, and data matches preload.
REQ-036 The bench SHALL cover rst_n pulsed low during ISSUE of a write of 32'hdeadbeef to addr 5 -> mem_we falls immediately, no done, addr 5 unchanged, state IDLE.
REQ-037 The bench SHALL cover port 1 writing 32'h12345678 to addr 7 and port 0 reading addr 7 in the next RESP -> rdata0=32'h12345678.
REQ-038 The bench SHALL check that mem_en & mem_we is never 1 and that gnt0 & gnt1 is never 1 in any scenario.
